instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 144 ++++++++++++++
 tb/tb_instruction_fetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: keeps one memory request in flight and feeds a
// 2-entry {pc, instr} buffer to the decoder. Redirects flush the buffer; a
// request abandoned by a redirect is drained and its response dropped.
// Optional build macro IFETCH_PERF_EN adds fetch_count / discard_count.
module instruction_fetch #(
  parameter int                ADDR_W   = 6,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              i_mem_req,
  output logic [ADDR_W-1:0] i_mem_addr,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              if_ready
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       discard_count
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
  } ent_t;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc, addr_q;
  logic              req_q;
  ent_t              fifo [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        cnt, cnt_pop, cnt_nxt;
  logic              pop, push, discard;
  logic [ADDR_W-1:0] pc_inc;

  // Head is visible unless a redirect is flushing it this cycle.
  assign if_valid   = (cnt != 2'd0) && !redirect_valid;
  assign if_instr   = fifo[rd_ptr].instr;
  assign if_pc      = fifo[rd_ptr].pc;
  assign i_mem_req  = req_q;
  assign i_mem_addr = addr_q;

  assign pop     = if_valid && if_ready;
  assign push    = (state == REQ) && i_mem_ack && !redirect_valid;
  assign discard = i_mem_ack && ((state == DRAIN) || ((state == REQ) && redirect_valid));
  assign cnt_pop = cnt - 2'(pop);
  assign cnt_nxt = cnt_pop + 2'(push);
  assign pc_inc  = pc + ADDR_W'(1);

  // Request FSM; req/addr are registered so they stay put until acked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
      req_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            pc     <= redirect_pc;
            addr_q <= redirect_pc;
            req_q  <= 1'b1;
            state  <= REQ;
          end else if (cnt_pop < 2'd2) begin
            addr_q <= pc;
            req_q  <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
            if (i_mem_ack) addr_q <= redirect_pc;  // response dropped, reissue at target
            else           state  <= DRAIN;        // old request still in flight
          end else if (i_mem_ack) begin
            pc     <= pc_inc;
            addr_q <= pc_inc;
            if (cnt_nxt >= 2'd2) begin
              req_q <= 1'b0;
              state <= IDLE;
            end
          end
        end
        DRAIN: begin
          // Keep the abandoned address on the bus until its response returns.
          if (redirect_valid) begin
            pc <= redirect_pc;
          end else if (i_mem_ack) begin
            addr_q <= pc;
            state  <= REQ;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry buffer; a redirect empties it in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) fifo[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (redirect_valid) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= '{pc: pc, instr: i_mem_data};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt_nxt;
    end
  end

`ifdef IFETCH_PERF_EN
  // Free-running 16-bit event counters, wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count   <= '0;
      discard_count <= '0;
    end else begin
      if (pop)     fetch_count   <= fetch_count + 16'd1;
      if (discard) discard_count <= discard_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed cycle table, then randomized traffic
// checked against a stream-level model of the expected fetch order.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_mem_req;
  logic [5:0]  i_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_data;
  logic        redirect_valid = 1'b0;
  logic [5:0]  redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [5:0]  if_pc;
  logic        if_ready = 1'b0;
`ifdef IFETCH_PERF_EN
  logic [15:0] fetch_count, discard_count;
`endif

  instruction_fetch #(.ADDR_W(6), .RESET_PC(6'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_req(i_mem_req), .i_mem_addr(i_mem_addr),
    .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready)
`ifdef IFETCH_PERF_EN
    , .fetch_count(fetch_count), .discard_count(discard_count)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: fixed one-cycle ack, or random latency in rand_mem mode.
  logic mack = 1'b0, fack = 1'b0, rand_mem = 1'b0;
  int   wait_cnt = 0;
  assign i_mem_ack  = mack | fack;
  assign i_mem_data = {24'd0, i_mem_addr, 2'b00};

  always @(posedge clk) begin
    if (!rand_mem) mack <= i_mem_req && !mack;
    else if (mack) mack <= 1'b0;
    else if (i_mem_req) begin
      if (wait_cnt == 0) begin
        mack     <= 1'b1;
        wait_cnt <= $urandom_range(0, 2);
      end else wait_cnt <= wait_cnt - 1;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, rdy, redir;
    logic [5:0]  rpc;
    logic        fack;
    logic        req;
    logic [5:0]  addr;
    logic        vld;
    logic [5:0]  pc;
    logic [31:0] instr;
  } vec_t;

  vec_t tv[$];

  task automatic row(input logic rst, rdy, redir, input logic [5:0] rpc, input logic fa,
                     input logic req, input logic [5:0] addr, input logic vld,
                     input logic [5:0] pc, input logic [31:0] instr);
    vec_t v;
    v = '{rst, rdy, redir, rpc, fa, req, addr, vld, pc, instr};
    tv.push_back(v);
  endtask

  initial begin
    logic [5:0] exp_pc, prev_addr;
    logic       prev_req, prev_ack;
    int         n_xfer;

    // rst rdy redir rpc fack | req addr vld pc instr
    // in-order stream with decoder always ready
    row(1,1,0,0,0, 0,0,0,0,0);
    row(0,1,0,0,0, 0,0,0,0,0);
    row(0,1,0,0,0, 1,0,0,0,0);
    row(0,1,0,0,0, 1,0,0,0,0);
    row(0,1,0,0,0, 1,1,1,0,0);
    row(0,1,0,0,0, 1,1,0,0,0);
    row(0,1,0,0,0, 1,2,1,1,4);
    row(0,1,0,0,0, 1,2,0,0,0);
    row(0,1,0,0,0, 1,3,1,2,8);
    row(0,1,0,0,0, 1,3,0,0,0);
    row(0,1,0,0,0, 1,4,1,3,12);
    // decoder stalled: buffer fills, requests stop, head holds
    row(1,0,0,0,0, 0,0,0,0,0);
    row(0,0,0,0,0, 0,0,0,0,0);
    row(0,0,0,0,0, 1,0,0,0,0);
    row(0,0,0,0,0, 1,0,0,0,0);
    row(0,0,0,0,0, 1,1,1,0,0);
    row(0,0,0,0,0, 1,1,1,0,0);
    row(0,0,0,0,0, 0,0,1,0,0);
    row(0,0,0,0,0, 0,0,1,0,0);
    row(0,1,0,0,0, 0,0,1,0,0);
    row(0,0,0,0,0, 1,2,1,1,4);
    // reset with a request out and one entry; stray ack in IDLE ignored
    row(1,1,0,0,0, 0,0,0,0,0);
    row(0,1,0,0,1, 0,0,0,0,0);
    row(0,1,0,0,0, 1,0,0,0,0);
    row(0,1,0,0,0, 1,0,0,0,0);
    row(0,1,0,0,0, 1,1,1,0,0);
    // redirect to 12 mid-request (drain), then redirect to 63 with ack (wrap)
    row(1,1,0,0,0, 0,0,0,0,0);
    row(0,1,0,0,0, 0,0,0,0,0);
    row(0,1,0,0,0, 1,0,0,0,0);
    row(0,1,0,0,0, 1,0,0,0,0);
    row(0,1,0,0,0, 1,1,1,0,0);
    row(0,1,0,0,0, 1,1,0,0,0);
    row(0,1,0,0,0, 1,2,1,1,4);
    row(0,1,0,0,0, 1,2,0,0,0);
    row(0,1,1,12,0, 1,3,0,0,0);
    row(0,1,0,0,0, 1,3,0,0,0);
    row(0,1,0,0,0, 1,12,0,0,0);
    row(0,1,0,0,0, 1,12,0,0,0);
    row(0,1,0,0,0, 1,13,1,12,48);
    row(0,1,1,63,0, 1,13,0,0,0);
    row(0,1,0,0,0, 1,63,0,0,0);
    row(0,1,0,0,0, 1,63,0,0,0);
    row(0,1,0,0,0, 1,0,1,63,252);
    row(0,1,0,0,0, 1,0,0,0,0);
    row(0,1,0,0,0, 1,1,1,0,0);

    foreach (tv[i]) begin
      @(negedge clk);
      rst_n          = !tv[i].rst;
      if_ready       = tv[i].rdy;
      redirect_valid = tv[i].redir;
      redirect_pc    = tv[i].rpc;
      fack           = tv[i].fack;
      #1;
      chk($sformatf("row%0d req", i), 32'(i_mem_req), 32'(tv[i].req));
      chk($sformatf("row%0d valid", i), 32'(if_valid), 32'(tv[i].vld));
      if (tv[i].req || tv[i].rst)
        chk($sformatf("row%0d addr", i), 32'(i_mem_addr), 32'(tv[i].addr));
      if (tv[i].vld || tv[i].rst) begin
        chk($sformatf("row%0d pc", i), 32'(if_pc), 32'(tv[i].pc));
        chk($sformatf("row%0d instr", i), if_instr, tv[i].instr);
      end
    end

    @(negedge clk);
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    #1;
`ifdef IFETCH_PERF_EN
    chk("fetch_count", 32'(fetch_count), 32'd5);
    chk("discard_count", 32'(discard_count), 32'd2);
`endif

    // Randomized traffic: every transfer must continue the expected pc stream.
    @(negedge clk);
    rst_n = 1'b0;
    rand_mem = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 6'd0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_addr = '0;
    n_xfer = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 6'($urandom_range(0, 63));
      #1;
      if (prev_req && !prev_ack) begin
        chk("req held", 32'(i_mem_req), 32'd1);
        chk("addr held", 32'(i_mem_addr), 32'(prev_addr));
      end
      if (redirect_valid) begin
        chk("valid on redirect", 32'(if_valid), 32'd0);
        exp_pc = redirect_pc;
      end else if (if_valid && if_ready) begin
        chk("rand pc", 32'(if_pc), 32'(exp_pc));
        chk("rand instr", if_instr, 32'(exp_pc) * 32'd4);
        exp_pc = exp_pc + 6'd1;
        n_xfer++;
      end
      prev_req  = i_mem_req;
      prev_ack  = i_mem_ack;
      prev_addr = i_mem_addr;
    end
    chk("rand progress", 32'(n_xfer > 300), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
